sub_serial_slice: RTL

- Multi-cycle two's-complement subtractor for the MIPS ALU datapath. Computes a - b one SLICE-bit slice per clock, LSB first, with a registered borrow chain.
- Trades latency for area: one narrow slice datapath replaces a full-width subtractor.
- Used for SUB/SUBU/SLT-style operations.
- Valid/ready handshake on both input and output sides.

---
 rtl/sub_serial_slice_pkg.sv | 23 ++
 rtl/sub_serial_slice_if.sv | 36 +++
 rtl/sub_serial_slice_slice_sub4.sv | 14 +
 rtl/sub_serial_slice.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sub_serial_slice_pkg.sv
// Shared types and sizing helpers for the serial-slice subtractor.
package sub_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 4;

  // Number of slices needed to cover the operand width.
  function automatic int calc_nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // Slice counter width; kept at least one bit so a single-slice build still has a counter.
  function automatic int calc_cnt_w(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/sub_serial_slice_if.sv
// Operand/result handshake bundle for sub_serial_slice.
// Build option SUB_SERIAL_SLICE_ADD_MODE_EN adds the op signal (0 = subtract, 1 = add).
interface sub_serial_slice_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SUB_SERIAL_SLICE_ADD_MODE_EN
  logic             op;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;
  logic             zero;

  modport master (
`ifdef SUB_SERIAL_SLICE_ADD_MODE_EN
    output op,
`endif
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow_out, overflow, zero
  );

  modport slave (
`ifdef SUB_SERIAL_SLICE_ADD_MODE_EN
    input  op,
`endif
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow_out, overflow, zero
  );

endinterface

// File: rtl/sub_serial_slice_slice_sub4.sv
// One combinational slice: res = a + ~b + cin, with carry-out.
module slice_sub4 #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             cin_i,
  output logic [SLICE-1:0] res_o,
  output logic             cout_o
);

  assign {cout_o, res_o} = {1'b0, a_i} + {1'b0, ~b_i} + {{SLICE{1'b0}}, cin_i};

endmodule

// File: rtl/sub_serial_slice.sv
// Multi-cycle a - b, one SLICE-bit slice per clock, LSB first, registered carry chain.
// Build option SUB_SERIAL_SLICE_ADD_MODE_EN adds an add operation selected by bus.op.
// WIDTH must be an integer multiple of SLICE.
module sub_serial_slice
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic                clk,
  input  logic                rst,
  sub_serial_slice_if.slave   bus
);

  localparam int NSLICE = calc_nslice(WIDTH, SLICE);
  localparam int CNT_W  = calc_cnt_w(NSLICE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic [SLICE-1:0]   sl_a;
  logic [SLICE-1:0]   sl_b;
  logic [SLICE-1:0]   sl_res;
  logic               sl_cout;
  logic               carry_init;
  logic               borrow_fin;
  logic               ovf_fin;

`ifdef SUB_SERIAL_SLICE_ADD_MODE_EN
  logic               op_q, op_d;

  // The slice always inverts b, so pre-inverting it turns the subtractor into an adder.
  assign sl_b       = op_q ? ~b_q[cnt_q*SLICE +: SLICE] : b_q[cnt_q*SLICE +: SLICE];
  assign carry_init = ~bus.op;
  assign borrow_fin = op_q ? sl_cout : ~sl_cout;
  assign ovf_fin    = op_q ? ((a_q[WIDTH-1] == b_q[WIDTH-1]) & (diff_d[WIDTH-1] != a_q[WIDTH-1]))
                           : ((a_q[WIDTH-1] != b_q[WIDTH-1]) & (diff_d[WIDTH-1] != a_q[WIDTH-1]));
`else
  assign sl_b       = b_q[cnt_q*SLICE +: SLICE];
  assign carry_init = 1'b1;
  assign borrow_fin = ~sl_cout;
  assign ovf_fin    = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (diff_d[WIDTH-1] != a_q[WIDTH-1]);
`endif

  assign sl_a = a_q[cnt_q*SLICE +: SLICE];

  slice_sub4 #(
    .SLICE (SLICE)
  ) u_slice (
    .a_i    (sl_a),
    .b_i    (sl_b),
    .cin_i  (carry_q),
    .res_o  (sl_res),
    .cout_o (sl_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand, counter, carry and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b1;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
`ifdef SUB_SERIAL_SLICE_ADD_MODE_EN
      op_q     <= 1'b0;
`endif
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
`ifdef SUB_SERIAL_SLICE_ADD_MODE_EN
      op_q     <= op_d;
`endif
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    cnt_d         = cnt_q;
    carry_d       = carry_q;
    diff_d        = diff_q;
    borrow_d      = borrow_q;
    ovf_d         = ovf_q;
    zero_d        = zero_q;
`ifdef SUB_SERIAL_SLICE_ADD_MODE_EN
    op_d          = op_q;
`endif
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          cnt_d   = '0;
          carry_d = carry_init;
`ifdef SUB_SERIAL_SLICE_ADD_MODE_EN
          op_d    = bus.op;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[cnt_q*SLICE +: SLICE] = sl_res;
        carry_d = sl_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          borrow_d = borrow_fin;
          ovf_d    = ovf_fin;
          zero_d   = (diff_d == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.overflow   = ovf_q;
  assign bus.zero       = zero_q;

endmodule
